// File: rtl/id_stage.sv
// RV32I(+M) decode stage: combinational decode of the incoming token feeding a
// two-entry (main + skid) output buffer with flush and fully registered handshakes.
module id_stage #(
    parameter bit ENABLE_M = 1'b1,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      aluc,
    output logic            write_reg,
    output logic            aluOut_WB_memOut,
    output logic            rs1Data_EX_PC,
    output logic [1:0]      rs2Data_EX_imm32_4,
    output logic            write_mem_1B,
    output logic            write_mem_2B,
    output logic            write_mem_4B,
    output logic            read_mem_1B,
    output logic            read_mem_2B,
    output logic            read_mem_4B,
    output logic            extension_mem,
    output logic [1:0]      not_NEXTPC_pcImm_rs1Imm,
    output logic [2:0]      branch_func3,
    output logic            illegal,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [31:0]     imm_32
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SLT  = 5'b00110;
    localparam logic [4:0] ALU_SLTU = 5'b00111;
    localparam logic [4:0] ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;

    typedef struct packed {
        logic [4:0]  aluc;
        logic        write_reg;
        logic        mem_to_reg;
        logic        pc_as_a;
        logic [1:0]  b_sel;
        logic        wm1;
        logic        wm2;
        logic        wm4;
        logic        rm1;
        logic        rm2;
        logic        rm4;
        logic        ext;
        logic [1:0]  next_pc;
        logic [2:0]  br_f3;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    // Base ALU op selected by func3 for OP / OP-IMM (func7 variants handled by caller).
    function automatic logic [4:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        bad;
    dec_t        dec;

    assign opcode = in_instr[6:0];
    assign func3  = in_instr[14:12];
    assign func7  = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec.write_reg = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.b_sel     = 2'b01;
                dec.imm       = imm_u;
            end
            OP_AUIPC: begin
                dec.write_reg = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.pc_as_a   = 1'b1;
                dec.b_sel     = 2'b01;
                dec.imm       = imm_u;
            end
            OP_JAL: begin
                dec.write_reg = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.pc_as_a   = 1'b1;
                dec.b_sel     = 2'b11;
                dec.next_pc   = 2'b01;
                dec.imm       = imm_j;
            end
            OP_JALR: begin
                bad           = (func3 != 3'b000);
                dec.write_reg = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.rs1       = in_instr[19:15];
                dec.pc_as_a   = 1'b1;
                dec.b_sel     = 2'b11;
                dec.next_pc   = 2'b10;
                dec.imm       = imm_i;
            end
            OP_LOAD: begin
                dec.write_reg  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.rd         = in_instr[11:7];
                dec.rs1        = in_instr[19:15];
                dec.b_sel      = 2'b01;
                dec.imm        = imm_i;
                case (func3)
                    3'b000:  begin dec.rm1 = 1'b1; dec.ext = 1'b1; end
                    3'b001:  begin dec.rm2 = 1'b1; dec.ext = 1'b1; end
                    3'b010:  dec.rm4 = 1'b1;
                    3'b100:  dec.rm1 = 1'b1;
                    3'b101:  dec.rm2 = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.rs1   = in_instr[19:15];
                dec.rs2   = in_instr[24:20];
                dec.b_sel = 2'b01;
                dec.imm   = imm_s;
                case (func3)
                    3'b000:  dec.wm1 = 1'b1;
                    3'b001:  dec.wm2 = 1'b1;
                    3'b010:  dec.wm4 = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.write_reg = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.rs1       = in_instr[19:15];
                dec.b_sel     = 2'b01;
                dec.imm       = imm_i;
                dec.aluc      = alu_of_f3(func3);
                // Shift-immediates reuse the upper immediate bits as func7.
                if (func3 == 3'b001) begin
                    bad = (func7 != 7'b0000000);
                end else if (func3 == 3'b101) begin
                    if (func7 == 7'b0100000) begin
                        dec.aluc = ALU_SRA;
                    end else if (func7 != 7'b0000000) begin
                        bad = 1'b1;
                    end
                end
            end
            OP_REG: begin
                dec.write_reg = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                if (func7 == 7'b0000000) begin
                    dec.aluc = alu_of_f3(func3);
                end else if (func7 == 7'b0100000 && func3 == 3'b000) begin
                    dec.aluc = ALU_SUB;
                end else if (func7 == 7'b0100000 && func3 == 3'b101) begin
                    dec.aluc = ALU_SRA;
                end else if (func7 == 7'b0000001 && ENABLE_M) begin
                    dec.aluc = {2'b10, func3};
                end else begin
                    bad = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec.rs1     = in_instr[19:15];
                dec.rs2     = in_instr[24:20];
                dec.next_pc = 2'b11;
                dec.br_f3   = func3;
                dec.imm     = imm_b;
                case (func3[2:1])
                    2'b00:   dec.aluc = ALU_SUB;
                    2'b10:   dec.aluc = ALU_SLT;
                    2'b11:   dec.aluc = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OP_FENCE: bad = (func3 != 3'b000);
            default:  bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    logic            accept, drain;
    logic            m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic            in_ready_q, in_ready_d;
    dec_t            m_dec_q, m_dec_d, s_dec_q, s_dec_d;
    logic [PC_W-1:0] m_pc_q, m_pc_d, s_pc_q, s_pc_d;

    assign accept = in_valid & in_ready_q;
    assign drain  = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_dec_d   = m_dec_q;
        s_dec_d   = s_dec_q;
        m_pc_d    = m_pc_q;
        s_pc_d    = s_pc_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || drain) begin
            // The skid entry is older than any new token, so it refills M first.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_dec_d   = s_dec_q;
                m_pc_d    = s_pc_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_dec_d   = dec;
                m_pc_d    = in_pc;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_dec_d   = dec;
            s_pc_d    = in_pc;
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b0;
            m_dec_q    <= '0;
            s_dec_q    <= '0;
            m_pc_q     <= '0;
            s_pc_q     <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
            m_dec_q    <= m_dec_d;
            s_dec_q    <= s_dec_d;
            m_pc_q     <= m_pc_d;
            s_pc_q     <= s_pc_d;
        end
    end

    assign in_ready                = in_ready_q;
    assign out_valid               = m_valid_q;
    assign out_pc                  = m_pc_q;
    assign aluc                    = m_dec_q.aluc;
    assign write_reg               = m_dec_q.write_reg;
    assign aluOut_WB_memOut        = m_dec_q.mem_to_reg;
    assign rs1Data_EX_PC           = m_dec_q.pc_as_a;
    assign rs2Data_EX_imm32_4      = m_dec_q.b_sel;
    assign write_mem_1B            = m_dec_q.wm1;
    assign write_mem_2B            = m_dec_q.wm2;
    assign write_mem_4B            = m_dec_q.wm4;
    assign read_mem_1B             = m_dec_q.rm1;
    assign read_mem_2B             = m_dec_q.rm2;
    assign read_mem_4B             = m_dec_q.rm4;
    assign extension_mem           = m_dec_q.ext;
    assign not_NEXTPC_pcImm_rs1Imm = m_dec_q.next_pc;
    assign branch_func3            = m_dec_q.br_f3;
    assign illegal                 = m_dec_q.illegal;
    assign rd                      = m_dec_q.rd;
    assign rs1                     = m_dec_q.rs1;
    assign rs2                     = m_dec_q.rs2;
    assign imm_32                  = m_dec_q.imm;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: two instances (M enabled / disabled) share stimulus;
// expected decodes come from a mnemonic-level reference model.
module tb_id_stage;
    localparam int PC_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        in_ready [2];
    logic        out_valid [2];
    logic [31:0] out_pc [2];
    logic [4:0]  aluc [2];
    logic        write_reg [2];
    logic        mem_out [2];
    logic        pc_a [2];
    logic [1:0]  b_sel [2];
    logic        wm1 [2];
    logic        wm2 [2];
    logic        wm4 [2];
    logic        rm1 [2];
    logic        rm2 [2];
    logic        rm4 [2];
    logic        ext [2];
    logic [1:0]  nxt [2];
    logic [2:0]  bf3 [2];
    logic        ill [2];
    logic [4:0]  rd [2];
    logic [4:0]  rs1 [2];
    logic [4:0]  rs2 [2];
    logic [31:0] imm [2];

    typedef struct packed {
        logic [4:0]  aluc;
        logic        wr;
        logic        mo;
        logic        pcs;
        logic [1:0]  sel;
        logic        wm1;
        logic        wm2;
        logic        wm4;
        logic        rm1;
        logic        rm2;
        logic        rm4;
        logic        ext;
        logic [1:0]  nxt;
        logic [2:0]  bf3;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t act [2];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            id_stage #(.ENABLE_M(gi == 0), .PC_W(PC_W)) dut (
                .clk(clk), .rst(rst),
                .in_valid(in_valid), .in_ready(in_ready[gi]),
                .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
                .out_valid(out_valid[gi]), .out_ready(out_ready), .out_pc(out_pc[gi]),
                .aluc(aluc[gi]), .write_reg(write_reg[gi]), .aluOut_WB_memOut(mem_out[gi]),
                .rs1Data_EX_PC(pc_a[gi]), .rs2Data_EX_imm32_4(b_sel[gi]),
                .write_mem_1B(wm1[gi]), .write_mem_2B(wm2[gi]), .write_mem_4B(wm4[gi]),
                .read_mem_1B(rm1[gi]), .read_mem_2B(rm2[gi]), .read_mem_4B(rm4[gi]),
                .extension_mem(ext[gi]), .not_NEXTPC_pcImm_rs1Imm(nxt[gi]),
                .branch_func3(bf3[gi]), .illegal(ill[gi]),
                .rd(rd[gi]), .rs1(rs1[gi]), .rs2(rs2[gi]), .imm_32(imm[gi])
            );
            assign act[gi] = {aluc[gi], write_reg[gi], mem_out[gi], pc_a[gi], b_sel[gi],
                              wm1[gi], wm2[gi], wm4[gi], rm1[gi], rm2[gi], rm4[gi], ext[gi],
                              nxt[gi], bf3[gi], ill[gi], rd[gi], rs1[gi], rs2[gi], imm[gi],
                              out_pc[gi]};
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // aluc by func3 for add/sll/slt/sltu/xor/srl/or/and
    localparam logic [4:0] ALU_TAB [8] = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd4, 5'd8, 5'd3, 5'd2};

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit en_m);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, si, bi, ui, ji;
        bit          bad;
        e   = '0;
        bad = 0;
        f3  = w[14:12];
        f7  = w[31:25];
        ii  = $signed(w) >>> 20;
        si  = {ii[31:5], w[11:7]};
        bi  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        ui  = w & 32'hFFFF_F000;
        ji  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h37: begin e.wr = 1; e.rd = w[11:7]; e.sel = 2'b01; e.imm = ui; end
            7'h17: begin e.wr = 1; e.rd = w[11:7]; e.pcs = 1; e.sel = 2'b01; e.imm = ui; end
            7'h6F: begin e.wr = 1; e.rd = w[11:7]; e.pcs = 1; e.sel = 2'b11; e.nxt = 2'b01; e.imm = ji; end
            7'h67: begin
                bad = (f3 != 0);
                e.wr = 1; e.rd = w[11:7]; e.rs1 = w[19:15]; e.pcs = 1;
                e.sel = 2'b11; e.nxt = 2'b10; e.imm = ii;
            end
            7'h03: begin
                bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.wr = 1; e.mo = 1; e.rd = w[11:7]; e.rs1 = w[19:15]; e.sel = 2'b01; e.imm = ii;
                e.rm1 = (f3[1:0] == 2'd0); e.rm2 = (f3[1:0] == 2'd1); e.rm4 = (f3[1:0] == 2'd2);
                e.ext = (f3 == 3'd0) || (f3 == 3'd1);
            end
            7'h23: begin
                bad = (f3 > 3'd2);
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.sel = 2'b01; e.imm = si;
                e.wm1 = (f3 == 3'd0); e.wm2 = (f3 == 3'd1); e.wm4 = (f3 == 3'd2);
            end
            7'h13: begin
                e.wr = 1; e.rd = w[11:7]; e.rs1 = w[19:15]; e.sel = 2'b01; e.imm = ii;
                e.aluc = ALU_TAB[f3];
                if (f3 == 3'd1) bad = (f7 != 0);
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) e.aluc = 5'd9;
                    else bad = (f7 != 0);
                end
            end
            7'h33: begin
                e.wr = 1; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                if (f7 == 0) e.aluc = ALU_TAB[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.aluc = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.aluc = 5'd9;
                else if (f7 == 7'h01 && en_m) e.aluc = 5'd16 + 5'(f3);
                else bad = 1;
            end
            7'h63: begin
                bad = (f3 == 3'd2) || (f3 == 3'd3);
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.nxt = 2'b11; e.bf3 = f3; e.imm = bi;
                e.aluc = (f3 < 3'd4) ? 5'd1 : ((f3 < 3'd6) ? 5'd6 : 5'd7);
            end
            7'h0F: bad = (f3 != 0);
            default: bad = 1;
        endcase
        if (bad) begin
            e     = '0;
            e.ill = 1;
        end
        e.pc = pc;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h03;  5: op = 7'h23;  6: op = 7'h13;  7: op = 7'h33;
            8: op = 7'h63;  9: op = 7'h0F;  default: op = w[6:0];
        endcase
        w[6:0] = op;
        if ((op == 7'h33 || op == 7'h13) && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: w[31:25] = 7'h01;
            endcase
        end
        if ((op == 7'h67 || op == 7'h0F) && $urandom_range(0, 1) != 0) w[14:12] = 3'd0;
        return w;
    endfunction

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e0, e1;
    int   n;
    logic seen_edge = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) seen_edge <= 1'b0;
        else     seen_edge <= 1'b1;
    end

    // Monitor + input bookkeeping: buffer occupancy equals the scoreboard depth.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            n = q0.size();
            chk("out_valid_m", out_valid[0], n > 0);
            chk("out_valid_nom", out_valid[1], n > 0);
            if (seen_edge) begin
                chk("in_ready_m", in_ready[0], n < 2);
                chk("in_ready_nom", in_ready[1], n < 2);
            end
            if (n > 0 && out_ready) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("decode_m", act[0], e0);
                chk("decode_nom", act[1], e1);
            end
            if (flush) begin
                q0.delete();
                q1.delete();
            end else if (in_valid && seen_edge && n < 2) begin
                q0.push_back(ref_decode(in_instr, in_pc, 1'b1));
                q1.push_back(ref_decode(in_instr, in_pc, 1'b0));
            end
        end
    end

    task automatic issue(input logic [31:0] w, input logic [31:0] pc);
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = w; in_pc = pc; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        #2;
        chk("reset_out_valid", out_valid[0], 1'b0);
        chk("reset_outputs_zero", act[0], '0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(32'h0050_0093, 32'h0000_0100);
        chk("addi_out_valid", out_valid[0], 1'b1);
        chk("addi_rd", rd[0], 5'd1);
        chk("addi_rs1", rs1[0], 5'd0);
        chk("addi_imm", imm[0], 32'd5);
        chk("addi_aluc", aluc[0], 5'b00000);
        chk("addi_write_reg", write_reg[0], 1'b1);
        chk("addi_bsel", b_sel[0], 2'b01);

        issue(32'hFE20_8EE3, 32'h0000_0104);
        chk("beq_rs1", rs1[0], 5'd1);
        chk("beq_rs2", rs2[0], 5'd2);
        chk("beq_imm", imm[0], 32'hFFFF_FFFC);
        chk("beq_aluc", aluc[0], 5'b00001);
        chk("beq_nextpc", nxt[0], 2'b11);
        chk("beq_func3", bf3[0], 3'b000);
        chk("beq_write_reg", write_reg[0], 1'b0);

        issue(32'h0220_81B3, 32'h0000_0108);
        chk("mul_m_aluc", aluc[0], 5'b10000);
        chk("mul_m_rd", rd[0], 5'd3);
        chk("mul_m_illegal", ill[0], 1'b0);
        chk("mul_nom_illegal", ill[1], 1'b1);
        chk("mul_nom_write_reg", write_reg[1], 1'b0);
        chk("mul_nom_rd", rd[1], 5'd0);

        // Stream of 4 with the consumer stalled for the first three cycles.
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 3);
            in_valid  = 1'b1;
            in_instr  = 32'h0000_0013 | (32'(idx) << 7);
            in_pc     = 32'h2000 + 32'(idx) * 4;
            @(negedge clk);
            if (c == 2) chk("stream_in_ready_full", in_ready[0], 1'b0);
            if (in_ready[0]) idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stream_all_accepted", idx, 4);
        repeat (4) @(posedge clk);

        // Fill both entries, then flush together with a new input.
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_instr = 32'h0010_0113; in_pc = 32'h3000 + 32'(k) * 4;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_full", in_ready[0], 1'b0);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3008;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid[0], 1'b0);
        chk("flush_in_ready", in_ready[0], 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of a stalled stream.
        #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h4000;
        @(posedge clk); #1;
        in_pc = 32'h4004;
        @(posedge clk); #3;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid[0], 1'b0);
        chk("async_rst_all_zero", act[0], '0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk);
        issue(32'h0000_007F, 32'h0000_5000);
        chk("post_rst_illegal", ill[0], 1'b1);
        chk("post_rst_illegal_valid", out_valid[0], 1'b1);

        // Randomized traffic with backpressure and occasional flushes.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_drained", q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
